// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// port identifiers and latency-counter width.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_ACK   = 2'd3
  } arb_state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_LOAD = 1'b1;

  // Wide enough for MEM_LATENCY-1 with MEM_LATENCY up to 15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin selector; on a tie the port that did
// not win last time is chosen.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = PORT_CORE;
    if (req0 && req1) begin
      gnt_id = ~last_grant;
    end else if (req1) begin
      gnt_id = PORT_LOAD;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core LSU (port 0) and the
// loader/DMA (port 1); one transaction at a time, round-robin on ties.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_id
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  arb_state_t       state;
  arb_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             gnt_valid;
  logic             gnt_id;
  logic             grant_fire;
  logic             capture;

  rr_pick2 u_pick (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ISSUE always hands over to WAIT; with MEM_LATENCY=1 the counter is
  // loaded with zero, so WAIT captures on its first cycle.
  always_comb begin
    state_next = state;
    grant_fire = 1'b0;
    capture    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (gnt_valid) begin
          grant_fire = 1'b1;
          state_next = ARB_ISSUE;
        end
      end
      ARB_ISSUE: state_next = ARB_WAIT;
      ARB_WAIT: begin
        if (cnt == '0) begin
          capture    = 1'b1;
          state_next = ARB_ACK;
        end
      end
      ARB_ACK:  state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      grant_id   <= PORT_CORE;
      last_grant <= PORT_LOAD;
      cnt        <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      mem_en <= grant_fire;
      if (grant_fire) begin
        mem_we     <= (gnt_id == PORT_LOAD) ? m1_we    : m0_we;
        mem_addr   <= (gnt_id == PORT_LOAD) ? m1_addr  : m0_addr;
        mem_wdata  <= (gnt_id == PORT_LOAD) ? m1_wdata : m0_wdata;
        grant_id   <= gnt_id;
        last_grant <= gnt_id;
      end

      if (state == ARB_ISSUE) begin
        cnt <= CNT_LOAD;
      end else if (state == ARB_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end

      m0_ack <= capture && (grant_id == PORT_CORE);
      m1_ack <= capture && (grant_id == PORT_LOAD);
      if (capture && grant_id == PORT_CORE) begin
        m0_rdata <= mem_rdata;
      end
      if (capture && grant_id == PORT_LOAD) begin
        m1_rdata <= mem_rdata;
      end
    end
  end

  assign busy = (state != ARB_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench: three arbiter instances (MEM_LATENCY 1, 3, 4) each with
// a memory model that only drives valid data in the exact sample cycle.
module tb_dmem_arbiter;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } iss_t;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        chk_rd;
    int          cyc;
  } ack_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic        m_req   [3][2];
  logic        m_we    [3][2];
  logic [31:0] m_addr  [3][2];
  logic [31:0] m_wdata [3][2];
  logic        m_ack   [3][2];
  logic [31:0] m_rdata [3][2];
  logic        mem_en    [3];
  logic        mem_we    [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];
  logic        busy      [3];
  logic        grant_id  [3];

  iss_t exp_iss [3][$];
  ack_t exp_ack [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return {16'hA5A5, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic fail_event(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: got %s (t=%0t)", name, what, $time);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);

    dmem_arbiter #(.AW(32), .DW(32), .MEM_LATENCY(LAT)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m0_req    (m_req[g][0]),
      .m0_we     (m_we[g][0]),
      .m0_addr   (m_addr[g][0]),
      .m0_wdata  (m_wdata[g][0]),
      .m0_ack    (m_ack[g][0]),
      .m0_rdata  (m_rdata[g][0]),
      .m1_req    (m_req[g][1]),
      .m1_we     (m_we[g][1]),
      .m1_addr   (m_addr[g][1]),
      .m1_wdata  (m_wdata[g][1]),
      .m1_ack    (m_ack[g][1]),
      .m1_rdata  (m_rdata[g][1]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g]),
      .grant_id  (grant_id[g])
    );

    // Memory model: data is valid only LAT cycles after the mem_en cycle.
    logic [15:0] pipe = '0;
    logic [31:0] store [256];
    logic        written [256];
    logic [31:0] rd_val;

    initial for (int k = 0; k < 256; k++) written[k] = 1'b0;

    always @(posedge clk) begin
      pipe <= {pipe[14:0], mem_en[g]};
      if (mem_en[g] && mem_we[g]) begin
        store[mem_addr[g][7:0]]   <= mem_wdata[g];
        written[mem_addr[g][7:0]] <= 1'b1;
      end
    end

    always_comb begin
      rd_val = written[mem_addr[g][7:0]] ? store[mem_addr[g][7:0]] : dflt(mem_addr[g]);
    end
    assign mem_rdata[g] = pipe[LAT-1] ? rd_val : 32'hBAD0_BAD0;

    always @(negedge clk) begin
      iss_t ei;
      ack_t ea;
      logic p;
      if (rst_n) begin
        if (mem_en[g]) begin
          if (exp_iss[g].size() == 0) begin
            fail_event($sformatf("u%0d_issue", g), "unexpected mem_en=1");
          end else begin
            ei = exp_iss[g].pop_front();
            check($sformatf("u%0d_issue_cycle", g), 32'(cyc), 32'(ei.cyc));
            check($sformatf("u%0d_mem_we", g), {31'b0, mem_we[g]}, {31'b0, ei.we});
            check($sformatf("u%0d_mem_addr", g), mem_addr[g], ei.addr);
            check($sformatf("u%0d_mem_wdata", g), mem_wdata[g], ei.wdata);
          end
        end
        if (m_ack[g][0] || m_ack[g][1]) begin
          check($sformatf("u%0d_ack_overlap", g), {31'b0, m_ack[g][0] & m_ack[g][1]}, 32'd0);
          p = m_ack[g][1];
          if (exp_ack[g].size() == 0) begin
            fail_event($sformatf("u%0d_ack", g), $sformatf("unexpected ack on port %0d", p));
          end else begin
            ea = exp_ack[g].pop_front();
            check($sformatf("u%0d_ack_port", g), {31'b0, p}, {31'b0, ea.port});
            check($sformatf("u%0d_ack_cycle", g), 32'(cyc), 32'(ea.cyc));
            if (ea.chk_rd) check($sformatf("u%0d_rdata", g), m_rdata[g][ea.port], ea.rdata);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Grant in IDLE cycle gc: mem_en at gc+1, ack at gc+2+lat.
  task automatic expect_txn(input int i, input logic p, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input int gc, input int lat,
                            input logic chk, input logic [31:0] rd, input logic with_ack);
    exp_iss[i].push_back('{we: w, addr: a, wdata: d, cyc: gc + 1});
    if (with_ack) exp_ack[i].push_back('{port: p, rdata: rd, chk_rd: chk, cyc: gc + 2 + lat});
  endtask

  // Hold a request until nack acks were seen, or for drop_after cycles.
  task automatic do_req(input int i, input int p, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int nack, input int drop_after);
    int seen = 0;
    int n = 0;
    m_we[i][p]    = w;
    m_addr[i][p]  = a;
    m_wdata[i][p] = d;
    m_req[i][p]   = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      n++;
      if (m_ack[i][p]) seen++;
      if ((nack > 0 && seen >= nack) || (drop_after > 0 && n >= drop_after)) break;
      if (n > 200) begin
        fail_event($sformatf("u%0d_p%0d_timeout", i, p), "no ack within 200 cycles");
        break;
      end
    end
    m_req[i][p] = 1'b0;
  endtask

  task automatic chk_zero(input int i, input string tag);
    check($sformatf("u%0d_%s_mem_en", i, tag), {31'b0, mem_en[i]}, 32'd0);
    check($sformatf("u%0d_%s_mem_we", i, tag), {31'b0, mem_we[i]}, 32'd0);
    check($sformatf("u%0d_%s_mem_addr", i, tag), mem_addr[i], 32'd0);
    check($sformatf("u%0d_%s_mem_wdata", i, tag), mem_wdata[i], 32'd0);
    check($sformatf("u%0d_%s_m0_ack", i, tag), {31'b0, m_ack[i][0]}, 32'd0);
    check($sformatf("u%0d_%s_m1_ack", i, tag), {31'b0, m_ack[i][1]}, 32'd0);
    check($sformatf("u%0d_%s_m0_rdata", i, tag), m_rdata[i][0], 32'd0);
    check($sformatf("u%0d_%s_m1_rdata", i, tag), m_rdata[i][1], 32'd0);
    check($sformatf("u%0d_%s_busy", i, tag), {31'b0, busy[i]}, 32'd0);
    check($sformatf("u%0d_%s_grant_id", i, tag), {31'b0, grant_id[i]}, 32'd0);
  endtask

  initial begin
    int c;
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < 2; p++) begin
        m_req[i][p]   = 1'b0;
        m_we[i][p]    = 1'b0;
        m_addr[i][p]  = '0;
        m_wdata[i][p] = '0;
      end
    end
    rst_n = 1'b0;
    tick(2);
    for (int i = 0; i < 3; i++) chk_zero(i, "reset");
    rst_n = 1'b1;
    tick(2);

    // Tie on L=1: grants 0,1,0,1 starting from reset priority.
    c = cyc;
    expect_txn(0, 1'b0, 1'b0, 32'h20, 32'h0, c,      1, 1'b1, 32'hA5A5_0020, 1'b1);
    expect_txn(0, 1'b1, 1'b0, 32'h40, 32'h0, c + 4,  1, 1'b1, 32'hA5A5_0040, 1'b1);
    expect_txn(0, 1'b0, 1'b0, 32'h20, 32'h0, c + 8,  1, 1'b1, 32'hA5A5_0020, 1'b1);
    expect_txn(0, 1'b1, 1'b0, 32'h40, 32'h0, c + 12, 1, 1'b1, 32'hA5A5_0040, 1'b1);
    fork
      do_req(0, 0, 1'b0, 32'h20, 32'h0, 2, 0);
      do_req(0, 1, 1'b0, 32'h40, 32'h0, 2, 0);
    join
    tick(2);

    // Single read on L=1 with busy window.
    c = cyc;
    expect_txn(0, 1'b0, 1'b0, 32'h10, 32'h0, c, 1, 1'b1, 32'hDEAD_BEEF, 1'b1);
    fork
      do_req(0, 0, 1'b0, 32'h10, 32'h0, 1, 0);
      begin
        tick(1);
        check("u0_busy_t1", {31'b0, busy[0]}, 32'd1);
        tick(1);
        check("u0_busy_t2", {31'b0, busy[0]}, 32'd1);
      end
    join
    tick(1);
    check("u0_busy_after_ack", {31'b0, busy[0]}, 32'd0);
    tick(1);

    // Late arrival: m1 raised while m0 is in flight.
    c = cyc;
    expect_txn(0, 1'b0, 1'b0, 32'h30, 32'h0, c,     1, 1'b1, 32'hA5A5_0030, 1'b1);
    expect_txn(0, 1'b1, 1'b0, 32'h34, 32'h0, c + 4, 1, 1'b1, 32'hA5A5_0034, 1'b1);
    fork
      do_req(0, 0, 1'b0, 32'h30, 32'h0, 1, 0);
      begin
        tick(2);
        do_req(0, 1, 1'b0, 32'h34, 32'h0, 1, 0);
      end
    join
    tick(2);

    // Write on L=3 from port 1, then read it back from port 0.
    c = cyc;
    expect_txn(1, 1'b1, 1'b1, 32'h8, 32'h1234_5678, c, 3, 1'b0, 32'h0, 1'b1);
    do_req(1, 1, 1'b1, 32'h8, 32'h1234_5678, 1, 0);
    tick(1);
    c = cyc;
    expect_txn(1, 1'b0, 1'b0, 32'h8, 32'h0, c, 3, 1'b1, 32'h1234_5678, 1'b1);
    do_req(1, 0, 1'b0, 32'h8, 32'h0, 1, 0);
    tick(1);

    // Request dropped during WAIT still completes.
    c = cyc;
    expect_txn(1, 1'b0, 1'b0, 32'h10, 32'h0, c, 3, 1'b1, 32'hDEAD_BEEF, 1'b1);
    do_req(1, 0, 1'b0, 32'h10, 32'h0, 0, 3);
    tick(3);
    check("u1_busy_after_drop", {31'b0, busy[1]}, 32'd0);
    tick(1);

    // Reset during WAIT on L=4: no ack afterwards, port 0 wins next tie.
    c = cyc;
    expect_txn(2, 1'b1, 1'b0, 32'h44, 32'h0, c, 4, 1'b0, 32'h0, 1'b0);
    do_req(2, 1, 1'b0, 32'h44, 32'h0, 0, 3);
    check("u2_busy_mid", {31'b0, busy[2]}, 32'd1);
    check("u2_grant_mid", {31'b0, grant_id[2]}, 32'd1);
    #1 rst_n = 1'b0;
    #1 chk_zero(2, "midrst");
    tick(2);
    rst_n = 1'b1;
    tick(10);
    c = cyc;
    expect_txn(2, 1'b0, 1'b0, 32'h50, 32'h0, c,     4, 1'b1, 32'hA5A5_0050, 1'b1);
    expect_txn(2, 1'b1, 1'b0, 32'h54, 32'h0, c + 7, 4, 1'b1, 32'hA5A5_0054, 1'b1);
    fork
      do_req(2, 0, 1'b0, 32'h50, 32'h0, 1, 0);
      do_req(2, 1, 1'b0, 32'h54, 32'h0, 1, 0);
    join
    tick(3);

    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d_pending_issue", i), 32'(exp_iss[i].size()), 32'd0);
      check($sformatf("u%0d_pending_ack", i), 32'(exp_ack[i].size()), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
